// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller.
// Segment patterns are active-high in gfedcba order; polarity is applied at the outputs.
package ssd_pkg;

  // All segments dark, in active-high form
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Hex digit glyphs 0..F, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

  // Clocks per digit dwell; never below 1 so the prescaler always has a legal range
  function automatic int calcDiv(input int clkHz, input int scanHz);
    int d;
    if (scanHz <= 0) begin
      return 1;
    end
    d = clkHz / scanHz;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Nibble to active-high seven-segment pattern (gfedcba).
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller with double-buffered data,
// frame-boundary display update, leading-zero blanking and output polarity control.
// Optional blink support is compiled in when SSD_BLINK_EN is defined.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
`ifdef SSD_BLINK_EN
  parameter int BLINK_FRAMES = 250,
`endif
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 5000000,
  parameter int SCAN_HZ     = 1000,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 1
) (
`ifdef SSD_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_done
);

  localparam int DIV = calcDiv(CLK_HZ, SCAN_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_INV    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV     = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_INV    = (SEL_ACT_LOW != 0) ? '1 : '0;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic                    r_frameDone;
  logic [4*NUM_DIGITS-1:0] r_shadowData;
  logic [NUM_DIGITS-1:0]   r_shadowDp;
  logic [4*NUM_DIGITS-1:0] r_dispData;
  logic [NUM_DIGITS-1:0]   r_dispDp;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;

  logic                    w_tick;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic                    w_lzRun;
  logic [NUM_DIGITS-1:0]   w_digitBlank;
  logic [3:0]              w_nib;
  logic                    w_dpReq;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_selOh;
  logic [6:0]              w_segDec;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Prescaler: free-running 0..DIV-1, tick marks the last count of each dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit index advances on each tick; the wrap raises a one-cycle frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_wrap;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Double buffer: loads go to the shadow, display only changes at a frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadowData <= '0;
      r_shadowDp   <= '0;
      r_dispData   <= '0;
      r_dispDp     <= '0;
      r_pending    <= 1'b0;
    end else if (load && w_wrap) begin
      r_shadowData <= data_in;
      r_shadowDp   <= dp_in;
      r_dispData   <= data_in;
      r_dispDp     <= dp_in;
      r_pending    <= 1'b0;
    end else if (load) begin
      r_shadowData <= data_in;
      r_shadowDp   <= dp_in;
      r_pending    <= 1'b1;
    end else if (w_wrap && r_pending) begin
      r_dispData   <= r_shadowData;
      r_dispDp     <= r_shadowDp;
      r_pending    <= 1'b0;
    end
  end

  // Leading-zero mask: walk down from the top digit until a nonzero nibble or a dp
  always_comb begin
    w_lzBlank = '0;
    w_lzRun   = lz_blank_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (w_lzRun && (r_dispData[4*i +: 4] == 4'h0) && !r_dispDp[i]) begin
        w_lzBlank[i] = 1'b1;
      end else begin
        w_lzRun = 1'b0;
      end
    end
  end

`ifdef SSD_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkOn;

  // Blink phase flips after every BLINK_FRAMES completed frames, starting in the on phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blinkCnt <= '0;
      r_blinkOn  <= 1'b1;
    end else if (r_frameDone) begin
      if (r_blinkCnt == BW'(BLINK_FRAMES - 1)) begin
        r_blinkCnt <= '0;
        r_blinkOn  <= ~r_blinkOn;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  assign w_digitBlank = w_lzBlank | (r_blinkOn ? '0 : blink_mask);
`else
  assign w_digitBlank = w_lzBlank;
`endif

  // Select the active digit's nibble, dp request, blank flag and one-hot enable
  always_comb begin
    w_nib   = '0;
    w_dpReq = 1'b0;
    w_blank = 1'b0;
    w_selOh = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib      = r_dispData[4*i +: 4];
        w_dpReq    = r_dispDp[i];
        w_blank    = w_digitBlank[i];
        w_selOh[i] = 1'b1;
      end
    end
  end

  ssd_hex_decode u_hexDecode (
    .i_nibble (w_nib),
    .o_seg    (w_segDec)
  );

  // Output registers: one cycle behind the index, polarity applied only here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_OFF ^ SEG_INV;
      r_dp  <= DP_INV;
      r_sel <= SEL_INV;
    end else begin
      r_seg <= (w_blank ? SEG_OFF : w_segDec) ^ SEG_INV;
      r_dp  <= (w_dpReq && !w_blank) ^ DP_INV;
      r_sel <= w_selOh ^ SEL_INV;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign sel        = r_sel;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4 and DIV=4 (CLK_HZ=8, SCAN_HZ=2).
// Expected glyphs below are active-low pin values.
module tb_ssd_scan_ctrl;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G5   = 7'b0010010;
  localparam logic [6:0] GA   = 7'b0001000;
  localparam logic [6:0] GF   = 7'b0001110;
  localparam logic [6:0] GOFF = 7'b1111111;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_blank_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  sel;
  logic        frame_done;
`ifdef SSD_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int checkCount = 0;
  int passCount  = 0;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .CLK_HZ      (8),
    .SCAN_HZ     (2),
    .SEG_ACT_LOW (1),
    .SEL_ACT_LOW (1)
  ) dut (
`ifdef SSD_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .load        (load),
    .lz_blank_en (lz_blank_en),
    .seg         (seg),
    .dp          (dp),
    .sel         (sel),
    .frame_done  (frame_done)
  );

  // Free-running 100 MHz-style clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Wait, bounded, for the frame pulse to be visible on a falling edge
  task automatic waitFrame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((frame_done !== 1'b1) && (n < 40));
    if (frame_done !== 1'b1) begin
      checkOutput({tag, "_timeout"}, {31'd0, frame_done}, 32'd1);
    end
  endtask

  // Walk one full frame from a frame pulse, checking every cycle; optionally load at step loadAt
  task automatic applyStimulus(input string name, input logic [27:0] expSeg,
                               input logic [3:0] expDp, input int loadAt,
                               input logic [15:0] ldData, input logic [3:0] ldDp);
    int d;
    logic [3:0] expSel;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      load   = 1'b0;
      d      = (k - 1) / 4;
      expSel = ~(4'b0001 << d);
      checkOutput({name, "_sel"}, {28'd0, sel}, {28'd0, expSel});
      checkOutput({name, "_seg"}, {25'd0, seg}, {25'd0, expSeg[d*7 +: 7]});
      checkOutput({name, "_dp"}, {31'd0, dp}, {31'd0, expDp[d]});
      checkOutput({name, "_frame"}, {31'd0, frame_done}, {31'd0, (k == 16)});
      if (k == loadAt) begin
        data_in = ldData;
        dp_in   = ldDp;
        load    = 1'b1;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    data_in     = 16'h0000;
    dp_in       = 4'b0000;
    load        = 1'b0;
    lz_blank_en = 1'b0;
`ifdef SSD_BLINK_EN
    blink_mask  = 4'b0000;
`endif

    // Reset held for three edges: everything dark and idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_sel", {28'd0, sel}, 32'hF);
      checkOutput("rst_seg", {25'd0, seg}, {25'd0, GOFF});
      checkOutput("rst_dp", {31'd0, dp}, 32'd1);
      checkOutput("rst_frame", {31'd0, frame_done}, 32'd0);
    end
    rst = 1'b0;

    // First cycle out of reset shows digit 0 with value 0; then queue 12AF
    @(negedge clk);
    checkOutput("first_sel", {28'd0, sel}, 32'hE);
    checkOutput("first_seg", {25'd0, seg}, {25'd0, G0});
    data_in = 16'h12AF;
    dp_in   = 4'b0000;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    waitFrame("scan_wait");

    // Plain scan of 12AF
    applyStimulus("scan", {G1, G2, GA, GF}, 4'b1111, 0, 16'h0000, 4'b0000);

    // Load 0000 while digit 1 is being scanned; this frame must stay 12AF
    applyStimulus("tear", {G1, G2, GA, GF}, 4'b1111, 5, 16'h0000, 4'b0000);

    // Zeros appear; load 3333 in the wrapping cycle
    applyStimulus("zero", {G0, G0, G0, G0}, 4'b1111, 15, 16'h3333, 4'b0000);
    checkOutput("coinc_pending", {31'd0, dut.r_pending}, 32'd0);
    applyStimulus("coinc", {G3, G3, G3, G3}, 4'b1111, 0, 16'h0000, 4'b0000);

    // Leading-zero blanking, then a dp stopping the blank run
    lz_blank_en = 1'b1;
    applyStimulus("lzpre", {G3, G3, G3, G3}, 4'b1111, 2, 16'h0050, 4'b0000);
    applyStimulus("lz", {GOFF, GOFF, G5, G0}, 4'b1111, 2, 16'h0050, 4'b0100);
    applyStimulus("lzdp", {GOFF, G0, G5, G0}, 4'b1011, 0, 16'h0000, 4'b0000);

    // One-cycle reset mid-frame with a load pending
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == 3) begin
        data_in = 16'h1234;
        dp_in   = 4'b0000;
        load    = 1'b1;
      end
      if (k == 6) begin
        rst = 1'b1;
      end
      if (k == 7) begin
        checkOutput("mid_rst_sel", {28'd0, sel}, 32'hF);
        checkOutput("mid_rst_seg", {25'd0, seg}, {25'd0, GOFF});
        checkOutput("mid_rst_dp", {31'd0, dp}, 32'd1);
        checkOutput("mid_rst_frame", {31'd0, frame_done}, 32'd0);
        rst         = 1'b0;
        lz_blank_en = 1'b0;
      end
      if (k == 8) begin
        checkOutput("mid_first_sel", {28'd0, sel}, 32'hE);
        checkOutput("mid_first_seg", {25'd0, seg}, {25'd0, G0});
      end
    end
    waitFrame("mid_wait");
    applyStimulus("post", {G0, G0, G0, G0}, 4'b1111, 0, 16'h0000, 4'b0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Parametrised N-digit multiplexed seven-segment display driver, the successor to the fixed 4-digit scan/decode logic in the UART board top.
- Holds a double-buffered hex value, scans digits at a programmable refresh rate and drives segment, decimal-point and digit-select lines.
- Adds tear-free frame-boundary update, leading-zero blanking and configurable output polarity.
- Sits between any datapath (UART RX data, counters) and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_HZ, 5000000: clk frequency in Hz.
- SCAN_HZ, 1000: per-digit dwell rate in Hz. DIV = CLK_HZ/SCAN_HZ, forced to a minimum of 1.
- SEG_ACT_LOW, 1: 1 = seg and dp are active-low.
- SEL_ACT_LOW, 1: 1 = sel is active-low.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit.
- dp_in  in  NUM_DIGITS  decimal-point request per digit; captured together with data_in.
- load  in  1  single-cycle strobe that captures data_in/dp_in into the shadow register.
- lz_blank_en  in  1  enables leading-zero blanking.
- seg  out  7  segment lines, gfedcba order.
- dp  out  1  decimal-point line.
- sel  out  NUM_DIGITS  one-hot digit enable.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Prescaler
  - Counts 0..DIV-1.
  - tick is asserted in the cycle the count equals DIV-1; the count then wraps to 0.
- Digit index
  - Increments on tick and wraps from NUM_DIGITS-1 to 0.
  - frame_done is registered and asserted for exactly the one cycle after the wrapping tick.
- Shadow buffering
  - On load: shadow <= data_in/dp_in and pending <= 1.
  - On the wrapping tick with pending=1: display <= shadow and pending <= 0.
  - If load and the wrapping tick occur in the same cycle: display and shadow both <= data_in, and pending stays 0.
  - A load that arrives mid-frame never alters digits already shown in the current frame; the display register is never torn.
- Output registers
  - seg, dp and sel are registered and reflect the digit index with exactly 1 cycle of latency.
  - Exactly one sel bit is active at any time after reset.
- Decode: hex 0..F uses the team's standard gfedcba pattern set. Examples in active-low form: 0 = 1000000, F = 0001110.
- Leading-zero blanking (lz_blank_en=1)
  - Scanning from digit NUM_DIGITS-1 downward, each zero nibble with dp=0 is blanked.
  - Blanking stops at the first nonzero nibble or the first digit with dp set.
  - Digit 0 is never blanked.
  - A blanked digit drives seg and dp off while its sel stays asserted.
- Polarity: the SEG_ACT_LOW and SEL_ACT_LOW inversions are applied at the output register only.
- Reset
  - prescaler, index, shadow, display and pending are cleared to 0.
  - frame_done = 0; seg and dp are off; all sel bits are inactive.
  - In the first cycle after rst deasserts, digit 0 is driven with value 0.
  - rst asserted mid-scan or mid-pending returns the block to this state on the next edge, and any pending load is discarded.

Optional Feature:
- Macro SSD_BLINK_EN.
- When defined:
  - Adds input port blink_mask (NUM_DIGITS bits) and parameter BLINK_FRAMES (default 250).
  - A blink phase bit toggles every BLINK_FRAMES frame_done pulses; reset sets it to the on phase.
  - During the off phase, masked digits are blanked, with the same rule as leading-zero blanking.
- When undefined: no port, no counter, and behaviour is identical to the base block.

Decomposition:
- Package ssd_pkg holds:
  - the 16-entry segment pattern constants and SEG_OFF;
  - the function computing DIV with its minimum of 1.
- One natural combinational sub-module, ssd_hex_decode (nibble -> 7-bit active-high pattern). It is instantiated once, on the muxed nibble.

Test Plan:
- Reset: NUM_DIGITS=4, CLK_HZ=8, SCAN_HZ=2 (DIV=4); hold rst for 3 cycles -> sel=1111, seg=1111111, dp=1, frame_done=0 throughout.
- Scan: load 16'h12AF, then wait for the frame boundary -> the sequence is sel=1110/seg=0001110, 1101/0001000, 1011/0100100, 0111/1111001. Each step is held 4 cycles, and frame_done pulses once per 16 cycles.
- Anti-tear: with 16'h12AF displayed, load 16'h0000 while digit 1 is active -> digits 1..3 still show A,2,1; all digits show 0 from the next digit 0 onward.
- Coincident load: assert load=16'h3333 on the wrapping tick cycle -> digit 0 of the very next frame shows 0110000, and pending remains 0.
- Blanking: lz_blank_en=1, data 16'h0050 -> digits 3 and 2 are off, digit 1 = 0010010, digit 0 = 1000000. Adding dp_in=0100 -> digit 2 shows 0 with dp on.
- Mid-operation reset: pulse rst for 1 cycle mid-frame with a load pending -> outputs return to the reset state, and display=0 after release.
